// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin merge of scalu/imul/lsq results
// into one registered writeback port toward the ROB.
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        scalu_valid,
  input  logic        scalu_error,
  input  logic [4:0]  scalu_ecause,
  input  logic [6:0]  scalu_robid,
  input  logic [5:0]  scalu_rd,
  input  logic [31:0] scalu_result,
  output logic        wb_scalu_stall,
  input  logic        imul_valid,
  input  logic        imul_error,
  input  logic [4:0]  imul_ecause,
  input  logic [6:0]  imul_robid,
  input  logic [5:0]  imul_rd,
  input  logic [31:0] imul_result,
  output logic        wb_imul_stall,
  input  logic        lsq_valid,
  input  logic        lsq_error,
  input  logic [4:0]  lsq_ecause,
  input  logic [6:0]  lsq_robid,
  input  logic [5:0]  lsq_rd,
  input  logic [31:0] lsq_result,
  output logic        wb_lsq_stall,
  output logic        wb_valid,
  output logic        wb_error,
  output logic [4:0]  wb_ecause,
  output logic [6:0]  wb_robid,
  output logic [5:0]  wb_rd,
  output logic [31:0] wb_result,
  input  logic        rob_wb_stall,
  input  logic        rob_flush
);

  typedef struct packed {
    logic        error;
    logic [4:0]  ecause;
    logic [6:0]  robid;
    logic [5:0]  rd;
    logic [31:0] result;
  } wb_pay_t;

  wb_pay_t    pay [3];
  wb_pay_t    sel;
  wb_pay_t    wb_q;
  logic [2:0] vld;
  logic [2:0] gnt;
  logic [1:0] last_grant;
  logic [1:0] start;
  logic [1:0] gnt_idx;
  logic       can_accept;
  logic       grant_en;
  logic       stall_en;

  assign pay[0] = {scalu_error, scalu_ecause,
                   scalu_robid, scalu_rd, scalu_result};
  assign pay[1] = {imul_error, imul_ecause,
                   imul_robid, imul_rd, imul_result};
  assign pay[2] = {lsq_error, lsq_ecause,
                   lsq_robid, lsq_rd, lsq_result};

  assign vld = {lsq_valid, imul_valid, scalu_valid};

  assign can_accept = ~wb_valid | ~rob_wb_stall;
  assign grant_en   = can_accept & ~rob_flush & ~rst;

  // flush clears stalls, but reset takes precedence over flush
  assign stall_en = ~(rob_flush & ~rst);

  assign start = (last_grant >= 2'd2) ? 2'd0
               : last_grant + 2'd1;

  always_comb begin
    gnt = '0;
    if (grant_en) begin
      case (start)
        2'd1: begin
          if      (vld[1]) gnt = 3'b010;
          else if (vld[2]) gnt = 3'b100;
          else if (vld[0]) gnt = 3'b001;
        end
        2'd2: begin
          if      (vld[2]) gnt = 3'b100;
          else if (vld[0]) gnt = 3'b001;
          else if (vld[1]) gnt = 3'b010;
        end
        default: begin
          if      (vld[0]) gnt = 3'b001;
          else if (vld[1]) gnt = 3'b010;
          else if (vld[2]) gnt = 3'b100;
        end
      endcase
    end
  end

  always_comb begin
    gnt_idx = last_grant;
    sel     = pay[0];
    unique case (1'b1)
      gnt[0]: begin gnt_idx = 2'd0; sel = pay[0]; end
      gnt[1]: begin gnt_idx = 2'd1; sel = pay[1]; end
      gnt[2]: begin gnt_idx = 2'd2; sel = pay[2]; end
      default: ;
    endcase
  end

  assign wb_scalu_stall = vld[0] & ~gnt[0] & stall_en;
  assign wb_imul_stall  = vld[1] & ~gnt[1] & stall_en;
  assign wb_lsq_stall   = vld[2] & ~gnt[2] & stall_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_q       <= '0;
      last_grant <= 2'd2;
    end else if (rob_flush) begin
      wb_valid <= 1'b0;
    end else if (can_accept) begin
      wb_valid <= |gnt;
      if (|gnt) begin
        wb_q       <= sel;
        last_grant <= gnt_idx;
      end
    end
  end

  assign wb_error  = wb_q.error;
  assign wb_ecause = wb_q.ecause;
  assign wb_robid  = wb_q.robid;
  assign wb_rd     = wb_q.rd;
  assign wb_result = wb_q.result;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: reference round-robin model feeding a
// scoreboard queue, directed scenarios then random traffic.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        scalu_valid, scalu_error;
  logic [4:0]  scalu_ecause;
  logic [6:0]  scalu_robid;
  logic [5:0]  scalu_rd;
  logic [31:0] scalu_result;
  logic        wb_scalu_stall;
  logic        imul_valid, imul_error;
  logic [4:0]  imul_ecause;
  logic [6:0]  imul_robid;
  logic [5:0]  imul_rd;
  logic [31:0] imul_result;
  logic        wb_imul_stall;
  logic        lsq_valid, lsq_error;
  logic [4:0]  lsq_ecause;
  logic [6:0]  lsq_robid;
  logic [5:0]  lsq_rd;
  logic [31:0] lsq_result;
  logic        wb_lsq_stall;
  logic        wb_valid, wb_error;
  logic [4:0]  wb_ecause;
  logic [6:0]  wb_robid;
  logic [5:0]  wb_rd;
  logic [31:0] wb_result;
  logic        rob_wb_stall;
  logic        rob_flush;

  typedef logic [50:0] pay_t;

  pay_t       sb_q[$];
  logic       m_wbv;
  int         m_last;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .scalu_valid(scalu_valid), .scalu_error(scalu_error),
    .scalu_ecause(scalu_ecause), .scalu_robid(scalu_robid),
    .scalu_rd(scalu_rd), .scalu_result(scalu_result),
    .wb_scalu_stall(wb_scalu_stall),
    .imul_valid(imul_valid), .imul_error(imul_error),
    .imul_ecause(imul_ecause), .imul_robid(imul_robid),
    .imul_rd(imul_rd), .imul_result(imul_result),
    .wb_imul_stall(wb_imul_stall),
    .lsq_valid(lsq_valid), .lsq_error(lsq_error),
    .lsq_ecause(lsq_ecause), .lsq_robid(lsq_robid),
    .lsq_rd(lsq_rd), .lsq_result(lsq_result),
    .wb_lsq_stall(wb_lsq_stall),
    .wb_valid(wb_valid), .wb_error(wb_error),
    .wb_ecause(wb_ecause), .wb_robid(wb_robid),
    .wb_rd(wb_rd), .wb_result(wb_result),
    .rob_wb_stall(rob_wb_stall), .rob_flush(rob_flush)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic pay_t src_pay(input int i);
    case (i)
      0: return {scalu_error, scalu_ecause, scalu_robid,
                 scalu_rd, scalu_result};
      1: return {imul_error, imul_ecause, imul_robid,
                 imul_rd, imul_result};
      default: return {lsq_error, lsq_ecause, lsq_robid,
                       lsq_rd, lsq_result};
    endcase
  endfunction

  // drive validity and per-source tagged payloads
  task automatic drive(input logic [2:0] v,
                       input logic st, input logic fl);
    scalu_valid  = v[0];
    imul_valid   = v[1];
    lsq_valid    = v[2];
    rob_wb_stall = st;
    rob_flush    = fl;
    scalu_error  = 1'b0; scalu_ecause = 5'd0;
    imul_error   = 1'b0; imul_ecause  = 5'd0;
    lsq_error    = 1'b0; lsq_ecause   = 5'd0;
    scalu_robid  = 7'd10; scalu_rd = 6'd1;
    imul_robid   = 7'd11; imul_rd  = 6'd2;
    lsq_robid    = 7'd12; lsq_rd   = 6'd3;
    scalu_result = 32'hA000_0000 | $urandom_range(0, 4095);
    imul_result  = 32'hB000_0000 | $urandom_range(0, 4095);
    lsq_result   = 32'hC000_0000 | $urandom_range(0, 4095);
  endtask

  // one clock: check stalls, predict grant, check registered output
  task automatic step();
    logic [2:0] v, expst;
    logic       ca;
    int         g;
    #1;
    v  = {lsq_valid, imul_valid, scalu_valid};
    ca = !m_wbv || !rob_wb_stall;
    g  = -1;
    if (ca && !rob_flush && !rst)
      for (int k = 1; k <= 3; k++) begin
        int idx;
        idx = (m_last + k) % 3;
        if (v[idx] && g < 0) g = idx;
      end
    expst = v;
    if (g >= 0) expst[g] = 1'b0;
    if (rob_flush && !rst) expst = 3'b000;
    check("stall",
          {wb_lsq_stall, wb_imul_stall, wb_scalu_stall}, expst);
    if (g >= 0) sb_q.push_back(src_pay(g));
    @(posedge clk);
    if (rst) begin
      sb_q.delete(); m_wbv = 1'b0; m_last = 2;
    end else if (rob_flush) begin
      sb_q.delete(); m_wbv = 1'b0;
    end else if (ca) begin
      if (m_wbv) void'(sb_q.pop_front());
      m_wbv = (g >= 0);
      if (g >= 0) m_last = g;
    end
    #1;
    check("wb_valid", wb_valid, m_wbv);
    if (m_wbv) begin
      check("sb_depth", sb_q.size(), 1);
      if (sb_q.size() > 0)
        check("wb_pay", {wb_error, wb_ecause, wb_robid,
                         wb_rd, wb_result}, sb_q[0]);
    end
    @(negedge clk);
  endtask

  initial begin
    m_wbv  = 1'b0;
    m_last = 2;
    rst    = 1'b1;
    drive(3'b000, 1'b0, 1'b0);
    step();
    step();
    check("rst_pay", {wb_error, wb_ecause, wb_robid,
                      wb_rd, wb_result}, '0);
    rst = 1'b0;

    // all valid one cycle: scalu first
    drive(3'b111, 1'b0, 1'b0);
    step();
    drive(3'b000, 1'b0, 1'b0);
    check("r032_robid", wb_robid, 7'd10);
    step();

    // all valid 6 cycles: rotating grant, full throughput
    for (int i = 0; i < 6; i++) begin
      drive(3'b111, 1'b0, 1'b0);
      step();
    end
    drive(3'b000, 1'b0, 1'b0);
    step();

    // held entry under ROB backpressure
    drive(3'b001, 1'b0, 1'b0);
    scalu_result = 32'h0000_00FF;
    step();
    for (int i = 0; i < 3; i++) begin
      drive(3'b010, 1'b1, 1'b0);
      step();
      check("r034_hold", wb_result, 32'h0000_00FF);
    end
    drive(3'b010, 1'b0, 1'b0);
    step();
    check("r034_imul", wb_robid, 7'd11);
    drive(3'b000, 1'b0, 1'b0);
    step();

    // exception forwarding from lsq
    drive(3'b100, 1'b0, 1'b0);
    lsq_error = 1'b1; lsq_ecause = 5'd4; lsq_robid = 7'd99;
    step();
    check("r035_exc", {wb_error, wb_ecause, wb_robid},
          {1'b1, 5'd4, 7'd99});

    // flush while held: stalls drop, entry dropped
    drive(3'b001, 1'b1, 1'b1);
    step();
    drive(3'b111, 1'b0, 1'b0);
    step();
    step();

    // reset mid-stall discards entry, pointer back to scalu
    drive(3'b010, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    drive(3'b111, 1'b1, 1'b1);
    step();
    check("r037_res", wb_result, 32'd0);
    rst = 1'b0;
    drive(3'b111, 1'b0, 1'b0);
    step();
    check("r037_scalu", wb_robid, 7'd10);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 19) == 0));
      scalu_error  = 1'($urandom);
      scalu_ecause = 5'($urandom);
      imul_robid   = 7'($urandom);
      lsq_rd       = 6'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
